// File: rtl/ascon_pkg.sv
// Shared Ascon types: the 320-bit permutation state, key slice bounds and the
// absorb-stage FSM encoding visible to the top-level controller.
package ascon_pkg;

    localparam int unsigned STATE_WORDS = 5;
    localparam int unsigned WORD_WIDTH  = 64;
    localparam int unsigned KEY_WIDTH   = 128;

    // Key word 1 comes from the upper half, word 2 from the lower half.
    localparam int unsigned KEY_HI_MSB = 127;
    localparam int unsigned KEY_HI_LSB = 64;
    localparam int unsigned KEY_LO_MSB = 63;
    localparam int unsigned KEY_LO_LSB = 0;

    typedef logic [STATE_WORDS-1:0][WORD_WIDTH-1:0] t_state_array;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_SEND
    } t_xor_begin_fsm;

endpackage

// File: rtl/xor_begin.sv
// Combinational absorb: XOR a rate block into word 0 and optionally the key
// into words 1-2; words 3-4 pass straight through.
module xor_begin
    import ascon_pkg::*;
#(
    parameter int unsigned RATE_WIDTH = 64
) (
    input  t_state_array          state_i,
    input  logic [RATE_WIDTH-1:0] data_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic                  apply_key_i,
    output t_state_array          state_o
);

    always_comb begin
        state_o    = state_i;
        state_o[0] = state_i[0] ^ data_i;
        if (apply_key_i) begin
            state_o[1] = state_i[1] ^ key_i[KEY_HI_MSB:KEY_HI_LSB];
            state_o[2] = state_i[2] ^ key_i[KEY_LO_MSB:KEY_LO_LSB];
        end
    end

endmodule

// File: rtl/xor_begin_ctrl.sv
// Absorb stage in front of the Ascon permutation: capture state, accept one
// rate block, present the updated state and optionally emit ciphertext.
module xor_begin_ctrl
    import ascon_pkg::*;
#(
    parameter int unsigned RATE_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  t_state_array          i_state,
    input  logic                  i_state_valid,
    input  logic [KEY_WIDTH-1:0]  i_key,
    input  logic                  i_mode_encrypt,
    input  logic                  i_enable_xor_key,
    input  logic [RATE_WIDTH-1:0] i_data,
    input  logic                  i_data_last,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output t_state_array          o_state,
    output logic                  o_state_last,
    output logic                  o_state_valid,
    input  logic                  i_state_ready,
    output logic [RATE_WIDTH-1:0] o_cipher,
    output logic                  o_cipher_valid
);

    t_xor_begin_fsm        fsm_q, fsm_d;
    t_state_array          state_q, state_d;
    t_state_array          absorbed;
    logic                  last_q, last_d;
    logic [RATE_WIDTH-1:0] cipher_q, cipher_d;
    logic                  cipher_valid_q, cipher_valid_d;

    xor_begin #(
        .RATE_WIDTH (RATE_WIDTH)
    ) u_xor_begin (
        .state_i     (state_q),
        .data_i      (i_data),
        .key_i       (i_key),
        .apply_key_i (i_data_last & i_enable_xor_key),
        .state_o     (absorbed)
    );

    always_comb begin
        fsm_d          = fsm_q;
        state_d        = state_q;
        last_d         = last_q;
        cipher_d       = cipher_q;
        cipher_valid_d = 1'b0;
        o_data_ready   = 1'b0;
        o_state_valid  = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                if (i_state_valid) begin
                    state_d = i_state;
                    fsm_d   = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                o_data_ready = 1'b1;
                if (i_data_valid) begin
                    state_d = absorbed;
                    last_d  = i_data_last;
                    if (i_mode_encrypt) begin
                        cipher_d       = absorbed[0];
                        cipher_valid_d = 1'b1;
                    end
                    fsm_d = S_SEND;
                end
            end
            S_SEND: begin
                // i_state_valid is ignored here so the held state cannot be clobbered.
                o_state_valid = 1'b1;
                if (i_state_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q          <= S_IDLE;
            state_q        <= '0;
            last_q         <= 1'b0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            state_q        <= state_d;
            last_q         <= last_d;
            cipher_q       <= cipher_d;
            cipher_valid_q <= cipher_valid_d;
        end
    end

    assign o_state        = state_q;
    assign o_state_last   = last_q;
    assign o_cipher       = cipher_q;
    assign o_cipher_valid = cipher_valid_q;

endmodule

// File: tb/tb_xor_begin_ctrl.sv
// Scoreboard bench for xor_begin_ctrl: directed blocks push expected results,
// a negedge monitor pops and compares when o_state_valid rises.
module tb_xor_begin_ctrl;
    import ascon_pkg::*;

    logic           clock;
    logic           reset_n;
    t_state_array   i_state;
    logic           i_state_valid;
    logic [127:0]   i_key;
    logic           i_mode_encrypt;
    logic           i_enable_xor_key;
    logic [63:0]    i_data;
    logic           i_data_last;
    logic           i_data_valid;
    logic           o_data_ready;
    t_state_array   o_state;
    logic           o_state_last;
    logic           o_state_valid;
    logic           i_state_ready;
    logic [63:0]    o_cipher;
    logic           o_cipher_valid;

    typedef struct {
        t_state_array st;
        logic         last;
        logic         cv;
        logic [63:0]  ci;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    xor_begin_ctrl #(
        .RATE_WIDTH (64)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_state          (i_state),
        .i_state_valid    (i_state_valid),
        .i_key            (i_key),
        .i_mode_encrypt   (i_mode_encrypt),
        .i_enable_xor_key (i_enable_xor_key),
        .i_data           (i_data),
        .i_data_last      (i_data_last),
        .i_data_valid     (i_data_valid),
        .o_data_ready     (o_data_ready),
        .o_state          (o_state),
        .o_state_last     (o_state_last),
        .o_state_valid    (o_state_valid),
        .i_state_ready    (i_state_ready),
        .o_cipher         (o_cipher),
        .o_cipher_valid   (o_cipher_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic t_state_array mk(input logic [63:0] w0, input logic [63:0] w1,
                                        input logic [63:0] w2, input logic [63:0] w3,
                                        input logic [63:0] w4);
        t_state_array s;
        s[0] = w0; s[1] = w1; s[2] = w2; s[3] = w3; s[4] = w4;
        return s;
    endfunction

    // Monitor: compare on the rising edge of o_state_valid, then enforce hold and single pulse.
    initial begin
        logic         prev_valid;
        t_state_array held;
        exp_t         e;
        prev_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (o_state_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_state_valid actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("state", o_state, e.st);
                        chk("state_last", o_state_last, e.last);
                        chk("cipher_valid", o_cipher_valid, e.cv);
                        if (e.cv) chk("cipher", o_cipher, e.ci);
                    end
                    held = o_state;
                end else begin
                    chk("cipher_single_pulse", o_cipher_valid, 1'b0);
                    if (o_state_valid) chk("state_hold", o_state, held);
                end
                prev_valid = o_state_valid;
            end
        end
    end

    task automatic capture(input t_state_array s);
        i_state       = s;
        i_state_valid = 1'b1;
        @(posedge clock); #1;
        i_state_valid = 1'b0;
        chk("ready_after_capture", o_data_ready, 1'b1);
    endtask

    task automatic absorb(input logic [63:0] d, input logic last, input logic enc,
                          input logic enk, input logic [127:0] key,
                          input t_state_array exp_st, input logic [63:0] exp_ci);
        exp_t e;
        i_data           = d;
        i_data_last      = last;
        i_mode_encrypt   = enc;
        i_enable_xor_key = enk;
        i_key            = key;
        i_data_valid     = 1'b1;
        e.st = exp_st; e.last = last; e.cv = enc; e.ci = exp_ci;
        exp_q.push_back(e);
        @(posedge clock); #1;
        i_data_valid     = 1'b0;
        i_mode_encrypt   = 1'b0;
        i_enable_xor_key = 1'b0;
        i_data_last      = 1'b0;
        i_key            = '0;
        chk("ready_drop_after_handshake", o_data_ready, 1'b0);
        chk("state_valid_after_handshake", o_state_valid, 1'b1);
    endtask

    task automatic release_send(input int hold);
        i_state_ready = 1'b0;
        repeat (hold) @(posedge clock);
        #1;
        i_state_ready = 1'b1;
        @(posedge clock); #1;
        i_state_ready = 1'b0;
        chk("state_valid_drop", o_state_valid, 1'b0);
    endtask

    localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [63:0]  W1  = 64'h1111_1111_1111_1111;
    localparam logic [63:0]  W2  = 64'h2222_2222_2222_2222;
    localparam logic [63:0]  W3  = 64'h3333_3333_3333_3333;
    localparam logic [63:0]  W4  = 64'h4444_4444_4444_4444;
    localparam logic [63:0]  W5  = 64'h5555_5555_5555_5555;
    localparam logic [63:0]  A5  = 64'hA5A5_A5A5_A5A5_A5A5;

    initial begin
        t_state_array zero;
        zero             = '0;
        reset_n          = 1'b0;
        i_state          = '0;
        i_state_valid    = 1'b0;
        i_key            = '0;
        i_mode_encrypt   = 1'b0;
        i_enable_xor_key = 1'b0;
        i_data           = '0;
        i_data_last      = 1'b0;
        i_data_valid     = 1'b0;
        i_state_ready    = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", o_state, '0);
        chk("rst_cipher", o_cipher, '0);
        chk("rst_flags", {o_state_valid, o_cipher_valid, o_state_last, o_data_ready}, 4'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("idle_not_ready", o_data_ready, 1'b0);
        end

        // AD absorb: word0 inverted, others untouched, no ciphertext
        capture(mk(W1, W2, W3, W4, W5));
        absorb(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, '0,
               mk(64'hEEEE_EEEE_EEEE_EEEE, W2, W3, W4, W5), '0);
        release_send(0);

        // Encrypt block
        capture(mk(64'h0123456789ABCDEF, A5, A5, A5, A5));
        absorb(64'h1111111111111111, 1'b0, 1'b1, 1'b0, '0,
               mk(64'h1032547698BADCFE, A5, A5, A5, A5), 64'h1032547698BADCFE);
        release_send(2);

        // Final key XOR
        capture(zero);
        absorb('0, 1'b1, 1'b0, 1'b1, KEY,
               mk('0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, '0, '0), '0);
        release_send(1);
        // Key enabled but not last: no key applied
        capture(zero);
        absorb('0, 1'b0, 1'b0, 1'b1, KEY, zero, '0);
        release_send(0);
        // Last but key disabled
        capture(zero);
        absorb(64'h0000_0000_0000_00FF, 1'b1, 1'b1, 1'b0, KEY,
               mk(64'h0000_0000_0000_00FF, '0, '0, '0, '0), 64'h0000_0000_0000_00FF);
        release_send(0);

        // Back-pressure with i_state_valid pulses that must be ignored
        capture(mk(W5, W4, W3, W2, W1));
        absorb(W1, 1'b0, 1'b0, 1'b0, '0, mk(64'h4444_4444_4444_4444, W4, W3, W2, W1), '0);
        i_state_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_state       = mk(64'(i), 64'(i + 1), 64'(i + 2), 64'(i + 3), 64'(i + 4));
            i_state_valid = (i % 2 == 0);
            @(posedge clock); #1;
        end
        i_state_valid = 1'b0;
        chk("bp_state_kept", o_state, mk(64'h4444_4444_4444_4444, W4, W3, W2, W1));
        chk("bp_valid_held", o_state_valid, 1'b1);
        // Release with a back-to-back i_state_valid: ignored at K, captured at K+1
        i_state       = mk(A5, A5, A5, A5, A5);
        i_state_valid = 1'b1;
        i_state_ready = 1'b1;
        @(posedge clock); #1;
        i_state_ready = 1'b0;
        chk("idle_after_release", {o_state_valid, o_data_ready}, 2'b00);
        i_state       = mk(W2, W3, W4, W5, W1);
        @(posedge clock); #1;
        i_state_valid = 1'b0;
        chk("capture_at_k_plus_1", o_data_ready, 1'b1);
        absorb('0, 1'b0, 1'b0, 1'b0, '0, mk(W2, W3, W4, W5, W1), '0);
        release_send(0);

        // Reset mid-operation during S_SEND
        capture(mk(W3, W3, W3, W3, W3));
        absorb(W1, 1'b1, 1'b1, 1'b0, '0,
               mk(64'h2222_2222_2222_2222, W3, W3, W3, W3), 64'h2222_2222_2222_2222);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_state_valid", o_state_valid, 1'b0);
        chk("midrst_state", o_state, '0);
        chk("midrst_flags", {o_cipher, o_state_last, o_data_ready}, 66'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("post_rst_idle", {o_state_valid, o_data_ready}, 2'b00);
        end
        capture(mk(64'h0123456789ABCDEF, W1, W2, W3, W4));
        absorb(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, KEY,
               mk(64'hFEDCBA9876543210, 64'h1110131215141716,
                  64'h2A2B28292E2F2C2D, W3, W4), 64'hFEDCBA9876543210);
        release_send(3);

        repeat (2) @(posedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_begin_ctrl.md
# xor_begin_ctrl

Sequential absorb stage at the front of the Ascon round pipeline, and the counterpart of the end-of-permutation XOR stage. It captures the state returned by the permutation and accepts one 64-bit rate block over a valid/ready handshake. It XORs the block into state word 0, and on the final block of a phase can also XOR the 128-bit key into words 1–2. It then presents the updated state to the permutation, and in encrypt mode emits the ciphertext word.

## Interface

Parameters:
- RATE_WIDTH, 64, width of one absorbed block; fixed to the 64-bit Ascon-128 rate, other values unsupported.

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_state  input  t_state_array  state from permutation/end stage
- i_state_valid  input  1  i_state valid this cycle
- i_key  input  128  key; [127:64] to word 1, [63:0] to word 2
- i_mode_encrypt  input  1  1: emit ciphertext, 0: absorb only (AD)
- i_enable_xor_key  input  1  apply key XOR when the accepted block has i_data_last=1
- i_data  input  RATE_WIDTH  rate block
- i_data_last  input  1  block is last of its phase
- i_data_valid  input  1  block valid
- o_data_ready  output  1  block accepted when valid & ready
- o_state  output  t_state_array  registered updated state
- o_state_last  output  1  o_state carries a last block
- o_state_valid  output  1  o_state valid
- i_state_ready  input  1  permutation accepts o_state
- o_cipher  output  RATE_WIDTH  ciphertext word (updated state word 0)
- o_cipher_valid  output  1  one-cycle pulse

## Operation

- FSM states: S_IDLE, S_WAIT_DATA, S_SEND.
- S_IDLE:
  - o_data_ready=0.
  - If i_state_valid=1, capture i_state into the state register and go to S_WAIT_DATA.
- S_WAIT_DATA:
  - o_data_ready=1.
  - On handshake, word0 ← word0 ^ i_data.
  - If i_data_last & i_enable_xor_key, also word1 ^= i_key[127:64] and word2 ^= i_key[63:0].
  - Words 3–4 pass through unchanged.
  - Register the result and o_state_last ← i_data_last.
  - If i_mode_encrypt, o_cipher ← new word0 and pulse o_cipher_valid.
  - Go to S_SEND.
- S_SEND:
  - o_state_valid=1 and o_state stays stable.
  - When i_state_ready=1, go to S_IDLE.
- i_state_valid outside S_IDLE is ignored; the state register is not overwritten.
- i_mode_encrypt, i_enable_xor_key and i_key are sampled only in the handshake cycle.
- All XORs are bitwise, with no carries and no width extension.

## Timing

- Reset (asynchronous, reset_n=0): FSM→S_IDLE; o_state, o_cipher = 0; o_state_valid, o_cipher_valid, o_state_last, o_data_ready = 0.
- Reset mid-operation: any in-flight block or state is discarded and no outputs are asserted afterwards until a new i_state_valid.
- Capture: i_state_valid at cycle N gives o_data_ready=1 from cycle N+1.
- Data handshake at cycle M:
  - o_state_valid=1 from cycle M+1.
  - o_cipher_valid=1 only at M+1.
  - o_data_ready=0 from M+1.
- Send: i_state_ready=1 at cycle K in S_SEND drops o_state_valid at K+1. Back-to-back i_state_valid at K is ignored; it is accepted from K+1.
- Back-pressure: o_state holds indefinitely while i_state_ready=0.
- Minimum turnaround is 3 cycles per block: capture, absorb, send.

## Structure

- ascon_pkg, existing: t_state_array.
- ascon_pkg, to add:
  - KEY_HI/KEY_LO slice constants.
  - t_xor_begin_fsm enum (S_IDLE, S_WAIT_DATA, S_SEND), shared with the top-level controller for state visibility.
- Sub-module xor_begin: purely combinational XOR of data and optional key into a t_state_array. This module instantiates it and supplies the registers, FSM and handshake.

## Test plan

- Reset then idle:
  - Hold reset_n=0 for 3 cycles, then release.
  - Required: all outputs 0, and o_data_ready=0 until i_state_valid.
- AD absorb:
  - State words = {0x1…,0x2…,0x3…,0x4…,0x5…}, data=0xFFFF_FFFF_FFFF_FFFF, encrypt=0.
  - Required: word0 = ~0x1…, words 1–4 unchanged, o_cipher_valid never asserted.
- Encrypt block:
  - State word0=0x0123456789ABCDEF, data=0x1111111111111111, encrypt=1.
  - Required: o_cipher=0x1032547698BADCFE, pulsing one cycle at M+1.
- Final key XOR:
  - i_data_last=1, enable_key=1, key=0x000102…0F, state all zero.
  - Required: word1=0x0001020304050607, word2=0x08090A0B0C0D0E0F, o_state_last=1.
  - With i_data_last=0, words 1–2 are unchanged.
- Back-pressure and ignore:
  - Hold i_state_ready=0 for 10 cycles while pulsing i_state_valid with new data.
  - Required: o_state stable and unchanged.
  - Required: i_state_ready=1 gives S_IDLE the next cycle.
- Reset mid-operation:
  - Assert reset_n=0 during S_SEND.
  - Required: o_state_valid drops immediately, and the next sequence behaves as from reset.
